// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StXfer = 1'b1
   } arb_state_e;

   localparam int unsigned DefaultMaxBurst = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         pick_o,
   output logic                 any_o
);

   localparam int unsigned PtrW = $clog2(N);

   logic [PtrW:0] idx;

   always_comb begin
      pick_o = '0;
      any_o  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr_i} + (PtrW + 1)'(k);
         if (idx >= (PtrW + 1)'(N)) idx = idx - (PtrW + 1)'(N);
         if (!any_o && req_i[idx[PtrW-1:0]]) begin
            pick_o[idx[PtrW-1:0]] = 1'b1;
            any_o                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting N_REQ producers bursts into one shared FIFO write port.
// Optional macro FIFO_WR_ARB_ASSERT_EN compiles in protocol assertions.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = DefaultMaxBurst
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]              req_last,
   output logic [N_REQ-1:0]              req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic [N_REQ-1:0]              grant,
   output logic                          busy
);

   localparam int unsigned PtrW  = $clog2(N_REQ);
   localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

   arb_state_e       state_q;
   logic [N_REQ-1:0] grant_q;
   logic [PtrW-1:0]  rr_ptr_q;
   logic [BeatW-1:0] beat_cnt_q;

   logic [N_REQ-1:0]      pick;
   logic                  pick_any;
   logic                  owner_valid;
   logic                  owner_last;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  beat_xfer;
   logic                  last_beat;
   logic [PtrW-1:0]       next_ptr;

   rr_pick #(
      .N (N_REQ)
   ) u_rr_pick (
      .req_i  (req_valid),
      .ptr_i  (rr_ptr_q),
      .pick_o (pick),
      .any_o  (pick_any)
   );

   // grant_q is all-zero in idle, so the owner view collapses to zero there.
   always_comb begin
      owner_valid = |(req_valid & grant_q);
      owner_last  = |(req_last & grant_q);
      owner_data  = '0;
      next_ptr    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            owner_data = owner_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            next_ptr   = (i == N_REQ - 1) ? '0 : PtrW'(i + 1);
         end
      end
   end

   assign busy       = (state_q == StXfer);
   assign grant      = grant_q;
   assign beat_xfer  = busy & owner_valid & ~fifo_full;
   assign last_beat  = owner_last | ((beat_cnt_q + BeatW'(1)) == BeatW'(MAX_BURST));
   assign req_ready  = (busy && !fifo_full) ? grant_q : '0;
   assign fifo_wr    = beat_xfer;
   assign fifo_wdata = busy ? owner_data : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_any) begin
                  state_q    <= StXfer;
                  grant_q    <= pick;
                  beat_cnt_q <= '0;
               end
            end
            StXfer: begin
               if (beat_xfer) begin
                  if (last_beat) begin
                     state_q    <= StIdle;
                     grant_q    <= '0;
                     beat_cnt_q <= '0;
                     rr_ptr_q   <= next_ptr;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + BeatW'(1);
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_ASSERT_EN
   a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_wr && fifo_full));

   a_busy_grant: assert property (@(posedge clk) disable iff (!reset_n)
      busy == (grant_q != '0));

   // Producers are expected to hold a stalled word; a change here is suspicious, not fatal.
   a_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (busy && owner_valid && fifo_full) |=> $stable(owner_data) || !$stable(grant_q))
      else $warning("owner data changed while stalled");
`endif

endmodule
